bootram_cpu_bridge: RTL and testbench

Bridges the picorv32 native memory interface (32-bit words, byte strobes, valid/ready) to the 2K×8 single-port boot RAM macro. Each word read becomes four sequential byte reads; each word write becomes four byte-lane write slots. It sits between the CPU bus decoder and the boot RAM instance. The decoder drives `mem_valid` only when the boot RAM region is selected.

---
 rtl/bootram_cpu_bridge.sv | 122 ++++++++++++
 tb/tb_bootram_cpu_bridge.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bootram_cpu_bridge.sv
// picorv32 native bus to 2Kx8 boot RAM bridge.
// Word accesses are serialised into four byte-lane RAM slots.
module bootram_cpu_bridge #(
  parameter int RAM_AW = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_rdata,
  output logic [RAM_AW-1:0] ram_ad,
  output logic [7:0]        ram_din,
  input  logic [7:0]        ram_dout,
  output logic              ram_ce,
  output logic              ram_wre,
  output logic              ram_oce,
  output logic              ram_reset
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    ACK
  } state_t;

  state_t state;
  state_t state_nx;

  logic [2:0]        phase;
  logic [RAM_AW-3:0] word_addr;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic [31:0]       rdata;
  logic [1:0]        lane;

  wire unused_addr = ^{mem_addr[31:RAM_AW], mem_addr[1:0]};

  // Read data lags the address by one slot, so phase N fills lane N-1.
  assign lane = phase[1:0] - 2'd1;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (mem_valid)
          state_nx = (mem_wstrb == 4'b0000) ? RD : WR;
      end
      RD:      if (phase == 3'd4) state_nx = ACK;
      WR:      if (phase == 3'd3) state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase     <= '0;
      word_addr <= '0;
      wdata     <= '0;
      wstrb     <= '0;
      rdata     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mem_valid) begin
            word_addr <= mem_addr[RAM_AW-1:2];
            wdata     <= mem_wdata;
            wstrb     <= mem_wstrb;
            phase     <= '0;
          end
        end
        RD: begin
          phase <= phase + 3'd1;
          if (phase != 3'd0)
            rdata[{lane, 3'b000} +: 8] <= ram_dout;
        end
        WR:      phase <= phase + 3'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_ready = 1'b0;
    ram_ce    = 1'b0;
    ram_wre   = 1'b0;
    ram_ad    = '0;
    ram_din   = '0;
    unique case (state)
      RD: begin
        if (phase <= 3'd3) begin
          ram_ce = 1'b1;
          ram_ad = {word_addr, phase[1:0]};
        end
      end
      WR: begin
        if (wstrb[phase[1:0]]) begin
          ram_ce  = 1'b1;
          ram_wre = 1'b1;
          ram_ad  = {word_addr, phase[1:0]};
          ram_din = wdata[{phase[1:0], 3'b000} +: 8];
        end
      end
      ACK:     mem_ready = 1'b1;
      default: ;
    endcase
  end

  assign mem_rdata = rdata;
  assign ram_oce   = 1'b1;
  assign ram_reset = reset;

endmodule

// File: tb/tb_bootram_cpu_bridge.sv
// Bench for bootram_cpu_bridge: RAM model plus word-level
// reference memory, directed cases then random traffic.
module tb_bootram_cpu_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic [10:0] ram_ad;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic        ram_ce;
  logic        ram_wre;
  logic        ram_oce;
  logic        ram_reset;

  bootram_cpu_bridge #(.RAM_AW(11)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .ram_ad    (ram_ad),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .ram_ce    (ram_ce),
    .ram_wre   (ram_wre),
    .ram_oce   (ram_oce),
    .ram_reset (ram_reset)
  );

  always #5 clk = ~clk;

  logic [7:0] ram_mem [2048];
  logic [7:0] ref_mem [2048];
  bit         loaded = 1'b0;
  int         cyc = 0;

  // Bypass-mode RAM: read data appears the cycle after the enabled edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!loaded) begin
      for (int i = 0; i < 2048; i++) ram_mem[i] <= 8'($urandom);
      ram_mem[0] <= 8'h6F;
      ram_mem[1] <= 8'h13;
      ram_mem[2] <= 8'h13;
      ram_mem[3] <= 8'h13;
      loaded <= 1'b1;
    end else if (ram_ce) begin
      if (ram_wre) ram_mem[ram_ad] <= ram_din;
      else         ram_dout <= ram_mem[ram_ad];
    end
  end

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_rdata = 32'h0;
  int          last_ack = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [21:0] pins();
    return {mem_ready, ram_ce, ram_wre, ram_ad, ram_din};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      mem_valid = 1'b0;
      @(negedge clk);
      chk("idle pins", 32'(pins()), 32'h0);
    end
  endtask

  task automatic txn(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd);
    logic [8:0]  wa;
    logic [21:0] e;
    logic [31:0] word;
    int          lat;
    @(posedge clk); #1;
    reset = 1'b0;
    mem_valid = 1'b1;
    mem_addr = a;
    mem_wdata = d;
    mem_wstrb = s;
    wa = a[10:2];
    lat = (s == 4'b0000) ? 6 : 5;
    word = {ref_mem[{wa, 2'd3}], ref_mem[{wa, 2'd2}],
            ref_mem[{wa, 2'd1}], ref_mem[{wa, 2'd0}]};
    @(negedge clk);
    chk("t0 pins", 32'(pins()), 32'h0);
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      mem_addr = $urandom;
      mem_wdata = $urandom;
      mem_wstrb = 4'($urandom);
      mem_valid = 1'($urandom);
      @(negedge clk);
      e = '0;
      if (k == lat) begin
        e[21] = 1'b1;
      end else if (s == 4'b0000) begin
        if (k <= 4) begin
          e[20] = 1'b1;
          e[18:8] = {wa, 2'(k - 1)};
        end
      end else if (s[k-1]) begin
        e[20] = 1'b1;
        e[19] = 1'b1;
        e[18:8] = {wa, 2'(k - 1)};
        e[7:0] = d[8*(k-1) +: 8];
      end
      chk($sformatf("pins a=%h s=%h k%0d", a, s, k),
          32'(pins()), 32'(e));
    end
    if (s == 4'b0000) exp_rdata = word;
    rd = mem_rdata;
    chk($sformatf("rdata a=%h s=%h", a, s), mem_rdata, exp_rdata);
    last_ack = cyc;
    for (int i = 0; i < 4; i++)
      if (s[i]) ref_mem[{wa, 2'(i)}] = d[8*i +: 8];
  endtask

  task automatic rst_mid_read(input logic [31:0] a);
    logic [8:0] wa;
    wa = a[10:2];
    @(posedge clk); #1;
    mem_valid = 1'b1;
    mem_addr = a;
    mem_wstrb = 4'b0000;
    @(negedge clk);
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk); #1;
      mem_valid = 1'b0;
      @(negedge clk);
      chk("rstrd pins", 32'(pins()),
          32'({1'b0, 1'b1, 1'b0, wa, 2'(k - 1), 8'h00}));
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstrd after pins", 32'(pins()), 32'h0);
    chk("rstrd after rdata", mem_rdata, 32'h0);
    exp_rdata = 32'h0;
    idle(6);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    int          t1;
    reset = 1'b1;
    mem_valid = 1'b1;
    mem_addr = 32'h0;
    mem_wdata = 32'h0;
    mem_wstrb = 4'h0;
    repeat (2) begin
      @(posedge clk); #1;
      reset = 1'b1;
      mem_valid = 1'b1;
      @(negedge clk);
      chk("reset pins", 32'(pins()), 32'h0);
      chk("reset rdata", mem_rdata, 32'h0);
      chk("ram_reset", 32'(ram_reset), 32'h1);
    end
    for (int i = 0; i < 2048; i++) ref_mem[i] = ram_mem[i];
    chk("ram_oce", 32'(ram_oce), 32'h1);

    txn(32'h0, 32'h0, 4'h0, rd);
    chk("preload word", rd, 32'h1313136F);
    chk("ram_reset low", 32'(ram_reset), 32'h0);
    idle(1);
    txn(32'h7FC, 32'hDEADBEEF, 4'hF, rd);
    txn(32'h7FC, 32'h0, 4'h0, rd);
    chk("full write rb", rd, 32'hDEADBEEF);
    txn(32'h7FC, 32'h00550000, 4'b0100, rd);
    txn(32'h7FC, 32'h0, 4'h0, rd);
    chk("partial write rb", rd, 32'hDE55BEEF);
    idle(2);

    rst_mid_read(32'h0);
    txn(32'h0, 32'h0, 4'h0, rd);
    chk("after reset rd", rd, 32'h1313136F);

    txn(32'h0, 32'h0, 4'h0, rd);
    t1 = last_ack;
    txn(32'h4, 32'h0, 4'h0, rd);
    chk("b2b gap", 32'(last_ack - t1), 32'd7);

    for (int n = 0; n < 80; n++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[10:4] = 7'h7F;
      d = $urandom;
      s = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
      txn(a, d, s, rd);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
